// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external combinational ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req0_op,
  input  logic [1:0]        req1_op,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [DATA_W-1:0] alu_srca,
  output logic [DATA_W-1:0] alu_srcb,
  output logic [1:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic [15:0]       ops_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] res_q;
  logic [3:0]        flags_q;
  logic              gnt_q;
  logic [15:0]       cnt_q;

  logic idle;
  logic in_resp;
  logic gnt1;
  logic accept;
  logic rsp_fire;

  // Handshake outputs stay quiet for the whole reset cycle.
  assign idle    = (state_q == IDLE) && !rst;
  assign in_resp = (state_q == RESP) && !rst;

`ifdef ALU_ARB_RR_EN
  logic last_q;

  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt1;
    end
  end
`else
  assign gnt1 = req1_valid & ~req0_valid;
`endif

  assign req0_ready = idle & req0_valid & ~gnt1;
  assign req1_ready = idle & gnt1;
  assign accept     = req0_ready | req1_ready;

  assign rsp0_valid = in_resp & ~gnt_q;
  assign rsp1_valid = in_resp & gnt_q;
  assign rsp_fire   = (rsp0_valid & rsp0_ready)
                    | (rsp1_valid & rsp1_ready);

  assign alu_srca   = a_q;
  assign alu_srcb   = b_q;
  assign alu_ctrl   = op_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign ops_count  = cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= gnt1 ? req1_a  : req0_a;
        b_q   <= gnt1 ? req1_b  : req0_b;
        op_q  <= gnt1 ? req1_op : req0_op;
        gnt_q <= gnt1;
      end
      if (state_q == EXEC) begin
        res_q   <= alu_result;
        flags_q <= alu_flags;
      end
      if (rsp_fire) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and arbitration model.
// Honours ALU_ARB_RR_EN to pick the expected arbitration policy.
module tb_alu_arbiter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0;
  logic          req1_valid = 1'b0;
  logic          req0_ready;
  logic          req1_ready;
  logic [W-1:0]  req0_a = '0;
  logic [W-1:0]  req0_b = '0;
  logic [W-1:0]  req1_a = '0;
  logic [W-1:0]  req1_b = '0;
  logic [1:0]    req0_op = '0;
  logic [1:0]    req1_op = '0;
  logic          rsp0_valid;
  logic          rsp1_valid;
  logic          rsp0_ready = 1'b0;
  logic          rsp1_ready = 1'b0;
  logic [W-1:0]  rsp_result;
  logic [3:0]    rsp_flags;
  logic [W-1:0]  alu_srca;
  logic [W-1:0]  alu_srcb;
  logic [1:0]    alu_ctrl;
  logic [W-1:0]  alu_result;
  logic [3:0]    alu_flags;
  logic [15:0]   ops_count;

  alu_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .ops_count(ops_count)
  );

  always #5 clk = ~clk;

  // Returns {N,Z,C,V, result}.
  function automatic logic [W+3:0] alu_model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [1:0]   op
  );
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'd1: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[W-1:0];
        c = ~s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {r[W-1], (r == '0), c, v, r};
  endfunction

  assign {alu_flags, alu_result} = alu_model(alu_srca, alu_srcb, alu_ctrl);

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] res;
    logic [3:0]   fl;
    int           acc;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        last_g = 1'b1;
  logic [15:0] exp_count = '0;
  bit          hold = 1'b0;
  bit          all_ready = 1'b0;
  bit          seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: compares presented responses and drives response readies.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_quiet", {rsp0_valid, rsp1_valid, req0_ready, req1_ready},
          4'b0000);
    end else begin
      chk("ops_count", ops_count, exp_count);
      if (rsp0_valid || rsp1_valid) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", {rsp1_valid, rsp0_valid}, 2'b00);
        end else begin
          chk("rsp_id", {rsp1_valid, rsp0_valid},
              q[0].id ? 2'b10 : 2'b01);
          chk("rsp_result", rsp_result, q[0].res);
          chk("rsp_flags", rsp_flags, q[0].fl);
          chk("alu_srca", alu_srca, q[0].a);
          chk("alu_srcb", alu_srcb, q[0].b);
          chk("alu_ctrl", alu_ctrl, q[0].op);
          if (!seen) begin
            chk("latency", cyc, q[0].acc + 2);
            seen = 1'b1;
          end
        end
      end
    end
    if (hold) begin
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
    end else if (all_ready) begin
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
    end else begin
      rsp0_ready = ($urandom % 4) != 0;
      rsp1_ready = ($urandom % 4) != 0;
    end
    if (!rst && q.size() != 0 &&
        ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
      void'(q.pop_front());
      seen = 1'b0;
      exp_count = exp_count + 16'd1;
    end
  end

  task automatic issue(input bit v0, input bit v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [1:0] o0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic [1:0] o1);
    bit           got;
    logic         g;
    exp_t         e;
    logic [W+3:0] m;
    got = 1'b0;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) got = 1'b1;
    end
    if (!got) begin
      timeout("accept_wait");
    end else begin
`ifdef ALU_ARB_RR_EN
      g = (v0 && v1) ? ~last_g : v1;
`else
      g = v1 && !v0;
`endif
      chk("grant", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
      last_g = g;
      e.id  = g;
      e.a   = g ? a1 : a0;
      e.b   = g ? b1 : b0;
      e.op  = g ? o1 : o0;
      m     = alu_model(e.a, e.b, e.op);
      e.res = m[W-1:0];
      e.fl  = m[W+3:W];
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) timeout("drain");
    @(negedge clk);
  endtask

  task automatic wait_rsp();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) got = 1'b1;
    end
    if (!got) timeout("rsp_wait");
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    q.delete();
    seen = 1'b0;
    exp_count = '0;
    last_g = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] p;
    logic [W-1:0] ra0, rb0, ra1, rb1;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_count", ops_count, 16'd0);
    chk("reset_result", rsp_result, '0);
    chk("reset_flags", rsp_flags, 4'd0);
    chk("reset_srcs", {alu_srca, alu_srcb, alu_ctrl}, '0);

    issue(1, 0, 5, 3, 2'd0, 0, 0, 2'd0);
    issue(0, 1, 32'h1234, 32'h0F0F, 2'd2, 32'h1234, 32'h0F0F, 2'd3);
    issue(1, 0, 7, 9, 2'd1, 0, 0, 2'd0);
    drain();
    chk("pre_rst_count", ops_count, 16'd3);

    hold = 1'b1;
    issue(0, 1, 0, 0, 2'd0, 11, 22, 2'd0);
    wait_rsp();
    assert_reset();
    @(negedge clk);
    chk("abort_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("abort_count", ops_count, 16'd0);
    chk("abort_result", rsp_result, '0);
    hold = 1'b0;

    all_ready = 1'b1;
    repeat (6) issue(1, 1, 10, 4, 2'd1, 32'hF0, 32'h3C, 2'd2);
    drain();
    all_ready = 1'b0;

    hold = 1'b1;
    issue(0, 1, 0, 0, 2'd0, 32'hFFFF_FFFF, 1, 2'd0);
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      req0_valid = 1'b1;
      @(negedge clk);
      chk("busy_ready", {req1_ready, req0_ready}, 2'b00);
      chk("carry_result", rsp_result, '0);
      chk("carry_valid", {rsp1_valid, rsp0_valid}, 2'b10);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    hold = 1'b0;
    drain();

    for (int n = 0; n < 40; n++) begin
      p = 2'($urandom_range(1, 3));
      ra0 = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
      rb0 = ($urandom % 4 == 0) ? 32'h8000_0000 : $urandom;
      ra1 = ($urandom % 4 == 0) ? 32'h7FFF_FFFF : $urandom;
      rb1 = ($urandom % 4 == 0) ? 32'h0 : $urandom;
      issue(p[0], p[1], ra0, rb0, 2'($urandom), ra1, rb1, 2'($urandom));
    end
    drain();

    all_ready = 1'b1;
    @(posedge clk);
    #1;
    force dut.cnt_q = 16'hFFFD;
    exp_count = 16'hFFFD;
    @(posedge clk);
    #1;
    release dut.cnt_q;
    issue(1, 0, 1, 2, 2'd0, 0, 0, 2'd0);
    issue(0, 1, 0, 0, 2'd0, 3, 4, 2'd3);
    drain();
    chk("count_ffff", ops_count, 16'hFFFF);
    issue(1, 1, 6, 6, 2'd1, 9, 9, 2'd2);
    drain();
    chk("count_wrap", ops_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
